key_schedule: RTL and testbench
===============================

// Module: key_schedule
// PURPOSE
//  Sequential AES key expansion (FIPS-197 sec. 5.2), directly upstream of the Cipher datapath.
//  Takes one cipher key and produces the complete round-key bus consumed by the Cipher `keys` input.
//  Generates one 32-bit word per clock, so a single SubWord unit serves all key sizes.
//  Holds the result stable until the next start.
// PARAMETERS
//  Nk  4       key length in 32-bit words (4/6/8 -> AES-128/192/256)
//  Nr  Nk+6    number of rounds; NW = 4*(Nr+1) expanded words (44/52/60)
// PORTS
//  clks        in   1               system clock, rising edge
//  reset       in   1               asynchronous, active-low reset
//  start       in   1               one-cycle request; sampled only in IDLE
//  key_in      in   Nk*32           cipher key, [0:31] = w[0] (big-endian word order)
//  busy        out  1               high from the edge accepting start until done
//  done        out  1               one-cycle pulse when expansion completes
//  keys_valid  out  1               level: keys holds a complete schedule
//  keys        out  (Nk*32)*(Nr+1)  round keys, [32*i +: 32] = w[i]; bits beyond 32*NW driven 0
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, busy=0, done=0, keys_valid=0, keys=0, all counters 0.
//  FSM IDLE -> EXPAND -> FINISH -> IDLE.
//  - IDLE: start=1 at edge E0 writes w[0..Nk-1]=key_in, i<=Nk, keys_valid<=0, busy<=1 -> EXPAND.
//  - EXPAND: each edge writes w[i], i<=i+1; at edge writing w[NW-1] -> FINISH.
//  - FINISH: done=1, keys_valid=1, busy=0 for this one cycle, then -> IDLE (done drops).
//  Latency: last word written at edge E(NW-Nk) (E40 for AES-128); done high the following cycle.
//  Word rule, with temp = w[i-1]:
//    i mod Nk == 0         -> temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk], 24'h0}
//    Nk > 6, i mod Nk == 4 -> temp = SubWord(temp)
//    w[i] = w[i-Nk] ^ temp
//  - No dividers: keep a mod-Nk phase counter (wraps Nk-1 -> 0) and an Rcon index (1..10),
//    incremented on each phase wrap.
//  - w[i-1] and w[i-Nk] come from an Nk-word sliding window register. Do not read back the wide bus.
//  - RotWord: byte rotate left {b1,b2,b3,b0}. Rcon is GF(2^8) doubling: 01,02,..,80,1b,36.
//  Boundaries:
//  - start while busy/FINISH: ignored, no effect on the running expansion.
//  - start in IDLE with keys_valid=1: keys_valid clears at E0. keys updates word-by-word while busy;
//    consumers use keys only when keys_valid=1.
//  - start asserted continuously: a new expansion begins every NW-Nk+2 cycles (re-accepted in IDLE).
//  - key_in is sampled only at E0; later changes do not affect the result.
//  - reset mid-expansion: immediate clear as above, partial schedule discarded.
// STRUCTURE
//  Shared package aes_pkg:
//  - Rcon table (10 x 8 bit)
//  - S-box table (256 x 8 bit)
//  - localparams for NW and the FSM state encoding
//  Sub-module sub_word: 32-bit combinational, four byte S-box lookups. Reused by the Cipher SubBytes.
//  Top-level holds the FSM, counters, window register and keys output register.
// TESTING
//  1. Nk=4, key 000102030405060708090a0b0c0d0e0f -> w[4]=d6aa74fd,
//     keys[1280+:128]=13111d7fe3944a17f307a78b4d2b30c5, done exactly 41 cycles after E0.
//  2. Nk=4, FIPS A.1 key 2b7e151628aed2a6abf7158809cf4f3c -> w[4]=a0fafe17, w[43]=b6630ca6.
//  3. Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202.
//  4. Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
//     -> w[8]=9ba35411, w[59]=706c631e.
//  5. Control:
//     - pulse start again at cycle 10 of a run -> ignored, result identical to test 1.
//     - drop reset at cycle 20 -> all outputs 0 immediately; a fresh start completes normally.
//  6. Chained with Cipher (Nk=4), keys from test 1, plaintext 00112233445566778899aabbccddeeff
//     -> encryptedText=69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key schedule and the Cipher datapath.
//   - SBOX    : forward S-box, 256 x 8 bit
//   - RCON    : round constants Rcon[1..10], 8 bit each
//   - ks_state_e : key-schedule FSM state encoding
//   - counter widths sized for the largest schedule (AES-256, 60 words)
//   - rot_word() : byte rotate-left helper used ahead of SubWord
// ---------------------------------------------------------------------------
package aes_pkg;

    // Largest expanded schedule in words (AES-256: 4 * (14 + 1)).
    localparam int MAX_NW  = 60;
    localparam int IDX_W   = $clog2(MAX_NW);
    // Phase counts i mod Nk, so it must hold 0..7.
    localparam int PHASE_W = 3;
    // Round-constant index runs 1..10.
    localparam int RCON_W  = 4;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_FINISH = 2'd2
    } ks_state_e;

    // Rcon[j] = x^(j-1) in GF(2^8); only the top byte of the word is non-zero.
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}, b0 being the most significant byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sub_word.sv
// ---------------------------------------------------------------------------
// sub_word
// Combinational AES SubWord: four independent byte lookups in the forward
// S-box. Shared between the key schedule and the Cipher SubBytes stage.
// Ports:
//   word_i  in  32  word to substitute
//   word_o  out 32  substituted word (byte-wise, position preserved)
// ---------------------------------------------------------------------------
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
        end
    end

endmodule

// File: rtl/key_schedule.sv
// ---------------------------------------------------------------------------
// key_schedule
// Sequential AES key expansion. One 32-bit schedule word is produced per
// clock so a single sub_word unit serves AES-128/192/256. The finished
// schedule is held on 'keys' until the next accepted start.
// Parameters:
//   Nk  key length in 32-bit words (4/6/8)
//   Nr  number of rounds (Nk+6); NW = 4*(Nr+1) schedule words
// Ports:
//   clks        in   1               rising-edge clock
//   reset       in   1               asynchronous active-low reset
//   start       in   1               expansion request, sampled only in IDLE
//   key_in      in   Nk*32           cipher key, most significant word = w[0]
//   busy        out  1               expansion in progress
//   done        out  1               one-cycle completion pulse
//   keys_valid  out  1               keys holds a complete schedule
//   keys        out  (Nk*32)*(Nr+1)  keys[32*i +: 32] = w[i], upper bits 0
// ---------------------------------------------------------------------------
module key_schedule
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
)
(
    input  logic                      clks,
    input  logic                      reset,
    input  logic                      start,
    input  logic [Nk*32-1:0]          key_in,
    output logic                      busy,
    output logic                      done,
    output logic                      keys_valid,
    output logic [(Nk*32)*(Nr+1)-1:0] keys
);

    localparam int NW = 4 * (Nr + 1);
    localparam int KW = (Nk * 32) * (Nr + 1);
    localparam int SW = 32 * NW;

    ks_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [RCON_W-1:0]  rcon_idx_q, rcon_idx_d;
    logic [31:0]        win_q [Nk];
    logic [31:0]        win_d [Nk];
    logic [SW-1:0]      keys_q, keys_d;
    logic               valid_q, valid_d;

    logic [31:0] prev_w;
    logic [31:0] old_w;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp_w;
    logic [31:0] new_w;
    logic        phase_zero;
    logic        phase_four;

    // Word datapath. The window holds w[i-Nk] (oldest, slot 0) through
    // w[i-1] (newest, slot Nk-1), so both operands come from local
    // registers rather than a wide mux on the output bus. The phase counter
    // stands in for i mod Nk; the extra SubWord step only exists for Nk > 6.
    always_comb begin
        prev_w     = win_q[Nk-1];
        old_w      = win_q[0];
        phase_zero = (phase_q == '0);
        phase_four = (Nk > 6) && (phase_q == PHASE_W'(4));
        sub_in     = phase_zero ? rot_word(prev_w) : prev_w;
        if (phase_zero) begin
            temp_w = sub_out ^ {RCON[rcon_idx_q], 24'h0};
        end else if (phase_four) begin
            temp_w = sub_out;
        end else begin
            temp_w = prev_w;
        end
        new_w = old_w ^ temp_w;
    end

    sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    // Next-state logic. IDLE loads the key into the window and the low
    // words of the schedule; EXPAND appends one word per edge and slides
    // the window; FINISH is the single done cycle before returning to IDLE.
    // The Rcon index saturates at 10 because the final phase wrap of
    // AES-128 would otherwise step past the table.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        rcon_idx_d = rcon_idx_q;
        win_d      = win_q;
        keys_d     = keys_q;
        valid_d    = valid_q;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            KS_IDLE: begin
                if (start) begin
                    for (int j = 0; j < Nk; j++) begin
                        win_d[j]            = key_in[32*(Nk-1-j) +: 32];
                        keys_d[32*j +: 32]  = key_in[32*(Nk-1-j) +: 32];
                    end
                    idx_d      = IDX_W'(Nk);
                    phase_d    = '0;
                    rcon_idx_d = RCON_W'(1);
                    valid_d    = 1'b0;
                    state_d    = KS_EXPAND;
                end
            end

            KS_EXPAND: begin
                busy = 1'b1;
                for (int j = 0; j < Nk - 1; j++) begin
                    win_d[j] = win_q[j+1];
                end
                win_d[Nk-1]              = new_w;
                keys_d[32*idx_q +: 32]   = new_w;
                idx_d                    = idx_q + IDX_W'(1);
                if (phase_q == PHASE_W'(Nk - 1)) begin
                    phase_d = '0;
                    if (rcon_idx_q != RCON_W'(10)) begin
                        rcon_idx_d = rcon_idx_q + RCON_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
                if (idx_q == IDX_W'(NW - 1)) begin
                    valid_d = 1'b1;
                    state_d = KS_FINISH;
                end
            end

            KS_FINISH: begin
                done    = 1'b1;
                state_d = KS_IDLE;
            end

            default: begin
                state_d = KS_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial schedule.
    always_ff @(posedge clks or negedge reset) begin
        if (!reset) begin
            state_q    <= KS_IDLE;
            idx_q      <= '0;
            phase_q    <= '0;
            rcon_idx_q <= '0;
            for (int j = 0; j < Nk; j++) begin
                win_q[j] <= '0;
            end
            keys_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            rcon_idx_q <= rcon_idx_d;
            win_q      <= win_d;
            keys_q     <= keys_d;
            valid_q    <= valid_d;
        end
    end

    // Output bus is wider than the schedule for Nk > 4; pad with zeros.
    always_comb begin
        keys          = '0;
        keys[SW-1:0]  = keys_q;
    end

    assign keys_valid = valid_q;

endmodule

// File: tb/tb_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_key_schedule
// Directed bench for key_schedule with one instance per key size
// (Nk = 4, 6, 8). Expected schedule words are FIPS-197 known answers.
// ---------------------------------------------------------------------------
module tb_key_schedule;

    localparam int KW4 = 128 * 11;
    localparam int KW6 = 192 * 13;
    localparam int KW8 = 256 * 15;

    logic             clks;
    logic             resetN;
    logic             start4, start6, start8;
    logic [127:0]     key4;
    logic [191:0]     key6;
    logic [255:0]     key8;
    logic             busy4, busy6, busy8;
    logic             done4, done6, done8;
    logic             valid4, valid6, valid8;
    logic [KW4-1:0]   keys4;
    logic [KW6-1:0]   keys6;
    logic [KW8-1:0]   keys8;

    int errors = 0;
    int checks = 0;
    int cnt;

    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY_192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY_256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_schedule #(.Nk(4)) u4 (
        .clks(clks), .reset(resetN), .start(start4), .key_in(key4),
        .busy(busy4), .done(done4), .keys_valid(valid4), .keys(keys4)
    );

    key_schedule #(.Nk(6)) u6 (
        .clks(clks), .reset(resetN), .start(start6), .key_in(key6),
        .busy(busy6), .done(done6), .keys_valid(valid6), .keys(keys6)
    );

    key_schedule #(.Nk(8)) u8 (
        .clks(clks), .reset(resetN), .start(start8), .key_in(key8),
        .busy(busy8), .done(done8), .keys_valid(valid8), .keys(keys8)
    );

    initial clks = 1'b0;
    always #5 clks = ~clks;

    // Hard stop in case something wedges the main sequence.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] wordOf(input int nk, input int i);
        case (nk)
            6:       return keys6[32*i +: 32];
            8:       return keys8[32*i +: 32];
            default: return keys4[32*i +: 32];
        endcase
    endfunction

    function automatic logic doneOf(input int nk);
        case (nk)
            6:       return done6;
            8:       return done8;
            default: return done4;
        endcase
    endfunction

    function automatic logic busyOf(input int nk);
        case (nk)
            6:       return busy6;
            8:       return busy8;
            default: return busy4;
        endcase
    endfunction

    function automatic logic validOf(input int nk);
        case (nk)
            6:       return valid6;
            8:       return valid8;
            default: return valid4;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveStart(input int nk, input logic s, input logic [255:0] key);
        case (nk)
            6: begin start6 = s; key6 = key[191:0]; end
            8: begin start8 = s; key8 = key;        end
            default: begin start4 = s; key4 = key[127:0]; end
        endcase
    endtask

    // Presents start for exactly one edge (E0) and leaves the bench at E0+1.
    task automatic applyStimulus(input int nk, input logic [255:0] key);
        @(negedge clks);
        driveStart(nk, 1'b1, key);
        @(posedge clks);
        #1;
        driveStart(nk, 1'b0, key);
        checkOutput($sformatf("nk%0d_busy_after_E0", nk), {31'b0, busyOf(nk)}, 32'd1);
        checkOutput($sformatf("nk%0d_valid_clear_E0", nk), {31'b0, validOf(nk)}, 32'd0);
    endtask

    // Counts edges after E0 until done is seen; optionally pulses start
    // with a different key after edge glitchAt to show it is ignored.
    task automatic waitDone(input int nk, input int glitchAt, output int edges);
        edges = 0;
        while (!doneOf(nk) && edges < 200) begin
            @(posedge clks);
            #1;
            edges++;
            if (glitchAt != 0 && edges == glitchAt) driveStart(nk, 1'b1, {256{1'b1}});
            else if (glitchAt != 0 && edges == glitchAt + 1) driveStart(nk, 1'b0, {256{1'b1}});
        end
    endtask

    // Full run: latency, status at done, and the one-cycle done pulse.
    task automatic runAndCheck(input int nk, input logic [255:0] key, input int glitchAt);
        int edges;
        applyStimulus(nk, key);
        waitDone(nk, glitchAt, edges);
        checkOutput($sformatf("nk%0d_done_edge", nk), edges, 32'(4 * (nk + 7) - nk));
        checkOutput($sformatf("nk%0d_busy_at_done", nk), {31'b0, busyOf(nk)}, 32'd0);
        checkOutput($sformatf("nk%0d_valid_at_done", nk), {31'b0, validOf(nk)}, 32'd1);
        @(posedge clks);
        #1;
        checkOutput($sformatf("nk%0d_done_pulse_end", nk), {31'b0, doneOf(nk)}, 32'd0);
        checkOutput($sformatf("nk%0d_valid_held", nk), {31'b0, validOf(nk)}, 32'd1);
    endtask

    initial begin
        resetN = 1'b0;
        driveStart(4, 1'b0, '0);
        driveStart(6, 1'b0, '0);
        driveStart(8, 1'b0, '0);

        // Reset state
        #3;
        checkOutput("rst_busy", {31'b0, busy4}, 32'd0);
        checkOutput("rst_done", {31'b0, done4}, 32'd0);
        checkOutput("rst_valid", {31'b0, valid4}, 32'd0);
        checkOutput("rst_keys_zero", {31'b0, |keys4}, 32'd0);
        @(negedge clks);
        resetN = 1'b1;

        // AES-128, incrementing key; done rises at E40 and occupies the 41st cycle
        runAndCheck(4, {128'b0, KEY_SEQ}, 0);
        checkOutput("seq_w0", wordOf(4, 0), 32'h00010203);
        checkOutput("seq_w3", wordOf(4, 3), 32'h0c0d0e0f);
        checkOutput("seq_w4", wordOf(4, 4), 32'hd6aa74fd);
        checkOutput("seq_w40", wordOf(4, 40), 32'h13111d7f);
        checkOutput("seq_w41", wordOf(4, 41), 32'he3944a17);
        checkOutput("seq_w42", wordOf(4, 42), 32'hf307a78b);
        checkOutput("seq_w43", wordOf(4, 43), 32'h4d2b30c5);

        // AES-128, FIPS A.1 key
        runAndCheck(4, {128'b0, KEY_FIPS}, 0);
        checkOutput("fips_w4", wordOf(4, 4), 32'ha0fafe17);
        checkOutput("fips_w43", wordOf(4, 43), 32'hb6630ca6);

        // Start pulse with a different key mid-run must be ignored
        runAndCheck(4, {128'b0, KEY_SEQ}, 10);
        checkOutput("glitch_w4", wordOf(4, 4), 32'hd6aa74fd);
        checkOutput("glitch_w40", wordOf(4, 40), 32'h13111d7f);
        checkOutput("glitch_w43", wordOf(4, 43), 32'h4d2b30c5);

        // Reset in the middle of an expansion clears everything at once
        applyStimulus(4, {128'b0, KEY_FIPS});
        repeat (19) @(posedge clks);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'b0, busy4}, 32'd0);
        checkOutput("midrst_done", {31'b0, done4}, 32'd0);
        checkOutput("midrst_valid", {31'b0, valid4}, 32'd0);
        checkOutput("midrst_keys_zero", {31'b0, |keys4}, 32'd0);
        #2;
        resetN = 1'b1;
        runAndCheck(4, {128'b0, KEY_FIPS}, 0);
        checkOutput("postrst_w4", wordOf(4, 4), 32'ha0fafe17);
        checkOutput("postrst_w43", wordOf(4, 43), 32'hb6630ca6);

        // Start held high: re-accepted every NW-Nk+2 = 42 cycles
        @(negedge clks);
        driveStart(4, 1'b1, {128'b0, KEY_SEQ});
        @(posedge clks);
        #1;
        checkOutput("cont_busy_E0", {31'b0, busy4}, 32'd1);
        waitDone(4, 0, cnt);
        checkOutput("cont_done_edge", cnt, 32'd40);
        @(posedge clks);
        #1;
        checkOutput("cont_idle_E41_busy", {31'b0, busy4}, 32'd0);
        checkOutput("cont_idle_E41_valid", {31'b0, valid4}, 32'd1);
        @(posedge clks);
        #1;
        checkOutput("cont_reaccept_E42_busy", {31'b0, busy4}, 32'd1);
        checkOutput("cont_reaccept_E42_valid", {31'b0, valid4}, 32'd0);
        driveStart(4, 1'b0, {128'b0, KEY_SEQ});
        waitDone(4, 0, cnt);
        checkOutput("cont_second_done_edge", cnt, 32'd40);
        checkOutput("cont_second_w43", wordOf(4, 43), 32'h4d2b30c5);

        // AES-192, FIPS A.2
        runAndCheck(6, {64'b0, KEY_192}, 0);
        checkOutput("k192_w6", wordOf(6, 6), 32'hfe0c91f7);
        checkOutput("k192_w51", wordOf(6, 51), 32'h01002202);
        checkOutput("k192_pad_zero", {31'b0, |keys6[KW6-1:1664]}, 32'd0);

        // AES-256, FIPS A.3
        runAndCheck(8, KEY_256, 0);
        checkOutput("k256_w8", wordOf(8, 8), 32'h9ba35411);
        checkOutput("k256_w59", wordOf(8, 59), 32'h706c631e);
        checkOutput("k256_pad_zero", {31'b0, |keys8[KW8-1:1920]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
